// File: rtl/mdclcg_word_prng.sv
// Modified dual-CLCG PRNG: four carry-save LCGs produce one bit per cycle,
// which is packed into WORD-bit words behind a valid/ready handshake.

module mdclcg_lcg #(
  parameter int unsigned   N = 32,
  parameter int unsigned   R = 2,
  parameter logic [N-1:0]  B = 1
) (
  input  logic [N-1:0] v,
  output logic [N-1:0] nxt
);
  logic [N-1:0] a, b, c, s, cy;

  // v + (v<<R) + B as a 3:2 compression followed by a single carry add
  assign a   = v;
  assign b   = v << R;
  assign c   = B;
  assign s   = a ^ b ^ c;
  assign cy  = ((a & b) | (a & c) | (b & c)) << 1;
  assign nxt = s + cy;
endmodule

module mdclcg_word_prng #(
  parameter int unsigned  N    = 32,
  parameter int unsigned  R1   = 2,
  parameter int unsigned  R2   = 3,
  parameter logic [N-1:0] B1   = 1,
  parameter logic [N-1:0] B2   = 3,
  parameter int unsigned  WORD = 8
) (
  input  logic            clk,
  input  logic            start,
  input  logic            seed_load,
  input  logic [N-1:0]    x0,
  input  logic [N-1:0]    y0,
  input  logic [N-1:0]    p0,
  input  logic [N-1:0]    q0,
  output logic            bit_out,
  output logic            bit_valid,
  output logic [WORD-1:0] word_out,
  output logic            word_valid,
  input  logic            word_ready
);
  localparam int unsigned CW = (WORD > 2) ? $clog2(WORD) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t state, state_nxt;

  // lane order: 0=x, 1=y, 2=p, 3=q; odd lanes use the (R2,B2) multiplier
  logic [3:0][N-1:0] st, nxt, seed;
  logic [WORD-2:0]   acc;
  logic [WORD-1:0]   acc_sh;
  logic [CW-1:0]     cnt;
  logic              z, step, stall;

  assign seed = {q0, p0, y0, x0};

  for (genvar g = 0; g < 4; g++) begin : g_lcg
    mdclcg_lcg #(
      .N (N),
      .R ((g % 2 == 1) ? R2 : R1),
      .B ((g % 2 == 1) ? B2 : B1)
    ) u_lcg (
      .v   (st[g]),
      .nxt (nxt[g])
    );
  end

  assign z      = (nxt[0] > nxt[1]) ^ (nxt[2] > nxt[3]);
  assign acc_sh = {acc, z};
  assign stall  = (cnt == LAST) && word_valid && !word_ready;

  always_comb begin
    state_nxt = state;
    step      = 1'b0;
    unique case (state)
      IDLE: if (seed_load) state_nxt = RUN;
      RUN: begin
        if (seed_load)  state_nxt = RUN;
        else if (stall) state_nxt = HOLD;
        else            step      = 1'b1;
      end
      HOLD: if (seed_load || word_ready) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (start) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (start) begin
      st         <= '0;
      acc        <= '0;
      cnt        <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
    end else begin
      bit_valid <= step;
      if (word_valid && word_ready) word_valid <= 1'b0;
      if (seed_load) begin
        st  <= seed;
        acc <= '0;
        cnt <= '0;
      end else if (step) begin
        st      <= nxt;
        bit_out <= z;
        acc     <= acc_sh[WORD-2:0];
        if (cnt == LAST) begin
          // a completing word overrides the handshake clear: no bubble
          cnt        <= '0;
          word_out   <= acc_sh;
          word_valid <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule
